// File: rtl/bcd_mul_seq.sv
// bcd_mul_seq: NDIG x NDIG digit BCD multiplier controller.
// Walks every digit pair (a_i, b_j), presents it to an external shared
// single-digit BCD multiplier, and BCD-accumulates the returned two-digit
// product at digit weight i+j into a 2*NDIG digit accumulator.
module bcd_mul_seq #(
  parameter int NDIG = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*NDIG-1:0]   a_bcd,
  input  logic [4*NDIG-1:0]   b_bcd,
  output logic [3:0]          mul_x,
  output logic [3:0]          mul_y,
  input  logic [3:0]          mul_h,
  input  logic [3:0]          mul_l,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [8*NDIG-1:0]   product
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_RUN,
    S_DONE
  } state_e;

  state_e                       state_q;
  logic [NDIG-1:0][3:0]         a_op_q;
  logic [NDIG-1:0][3:0]         b_op_q;
  logic [IW-1:0]                i_q;
  logic [IW-1:0]                j_q;
  logic [2*NDIG-1:0][3:0]       acc_q;
  logic [2*NDIG-1:0][3:0]       acc_d;
  logic [8*NDIG-1:0]            product_q;
  logic                         busy_q;
  logic                         done_q;
  logic                         err_q;
  logic                         op_bad;
  logic [IW:0]                  ij;

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign product = product_q;
  assign ij      = {1'b0, i_q} + {1'b0, j_q};

  // Flag any latched operand digit outside 0..9.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    op_bad = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (a_op_q[k] > 4'd9 || b_op_q[k] > 4'd9) op_bad = 1'b1;
    end
  end

  // Present the current digit pair to the shared multiplier; zero outside RUN.
  always_comb begin
    mul_x = 4'd0;
    mul_y = 4'd0;
    if (state_q == S_RUN) begin
      mul_x = a_op_q[i_q];
      mul_y = b_op_q[j_q];
    end
  end

  // BCD-add the shifted partial product into the accumulator, carry rippling
  // through every higher digit. The carry out of the top digit cannot occur for
  // valid BCD operands, so it is dropped.
  always_comb begin
    logic [2*NDIG-1:0][3:0] addend;
    logic [4:0]             s;
    logic                   c;
    addend = {{(8*NDIG-8){1'b0}}, mul_h, mul_l} << {ij, 2'b00};
    acc_d  = '0;
    c      = 1'b0;
    for (int k = 0; k < 2*NDIG; k++) begin
      s = {1'b0, acc_q[k]} + {1'b0, addend[k]} + {4'd0, c};
      if (s > 5'd9) begin
        acc_d[k] = s[3:0] + 4'd6;
        c        = 1'b1;
      end else begin
        acc_d[k] = s[3:0];
        c        = 1'b0;
      end
    end
  end

  // Control FSM with registered status outputs and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_op_q    <= '0;
      b_op_q    <= '0;
      i_q       <= '0;
      j_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_op_q  <= a_bcd;
            b_op_q  <= b_bcd;
            busy_q  <= 1'b1;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (op_bad) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          if (i_q == LAST_IDX) begin
            i_q <= '0;
            if (j_q == LAST_IDX) begin
              j_q       <= '0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              product_q <= acc_d;
              state_q   <= S_DONE;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_mul_seq.sv
// Self-checking bench for bcd_mul_seq (NDIG = 8): table-driven operations plus
// hand-written sequences for start-while-busy and mid-run reset.
module tb_bcd_mul_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a_bcd;
  logic [31:0] b_bcd;
  logic [3:0]  mul_x;
  logic [3:0]  mul_y;
  logic [3:0]  mul_h;
  logic [3:0]  mul_l;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] product;

  int checks = 0;
  int errors = 0;

  bcd_mul_seq #(.NDIG(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_bcd   (a_bcd),
    .b_bcd   (b_bcd),
    .mul_x   (mul_x),
    .mul_y   (mul_y),
    .mul_h   (mul_h),
    .mul_l   (mul_l),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference single-digit BCD multiplier.
  always_comb begin
    logic [7:0] p;
    p     = 8'(mul_x) * 8'(mul_y);
    mul_h = 4'(p / 8'd10);
    mul_l = 4'(p % 8'd10);
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    logic        e;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic longint unsigned bcd2dec(input logic [63:0] v);
    longint unsigned r = 0;
    for (int k = 15; k >= 0; k--) r = r * 10 + longint'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic bit digit_bad(input logic [63:0] v);
    bit bad = 0;
    for (int k = 0; k < 16; k++) if (v[4*k +: 4] > 4'd9) bad = 1;
    return bad;
  endfunction

  // Issue one operation starting at a negedge; returns at the negedge after the
  // done cycle. Cycle n is the n-th negedge after the accepting edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit inject,
                        output logic [63:0] prod, output logic e, output int dcyc,
                        output bit inv_ok);
    int n;
    int k;
    int ii;
    int jj;
    logic [63:0] acc;
    a_bcd = a;
    b_bcd = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    n      = 1;
    dcyc   = -1;
    inv_ok = 1;
    e      = 1'bx;
    prod   = 'x;
    while (dcyc < 0 && n <= 200) begin
      acc = dut.acc_q;
      if (busy && (done || err)) inv_ok = 0;
      if (!busy && (mul_x != 4'd0 || mul_y != 4'd0)) inv_ok = 0;
      if (digit_bad(acc)) inv_ok = 0;
      if (n >= 2 && n <= 65 && busy) begin
        k  = n - 2;
        ii = k % 8;
        jj = k / 8;
        if (mul_x !== a[4*ii +: 4] || mul_y !== b[4*jj +: 4]) inv_ok = 0;
        if (bcd2dec(acc) + longint'(mul_x) * longint'(mul_y) * pow10(ii + jj)
            >= 64'd10000000000000000) inv_ok = 0;
      end
      if (done) begin
        dcyc = n;
        e    = err;
        prod = product;
      end
      if (inject && n == 11) begin
        start = 1'b1;
        a_bcd = 32'h99999999;
      end else begin
        start = 1'b0;
      end
      if (dcyc < 0) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    if (done || err) inv_ok = 0;
  endtask

  initial begin
    logic [63:0] p;
    logic        e;
    int          dc;
    bit          ok;
    int          extra_done;

    vecs[0] = '{32'h12345678, 32'h87654321, 64'h1082152022374638, 1'b0};
    vecs[1] = '{32'h99999999, 32'h99999999, 64'h9999999800000001, 1'b0};
    vecs[2] = '{32'h00000000, 32'h87654321, 64'h0000000000000000, 1'b0};
    vecs[3] = '{32'h00000001, 32'h00000007, 64'h0000000000000007, 1'b0};
    vecs[4] = '{32'h1234A678, 32'h00000005, 64'h0000000000000007, 1'b1};
    vecs[5] = '{32'h11111111, 32'h11111111, 64'h0123456787654321, 1'b0};
    vecs[6] = '{32'h00000999, 32'h00001001, 64'h0000000000999999, 1'b0};
    vecs[7] = '{32'h50000000, 32'h00000002, 64'h0000000100000000, 1'b0};
    vecs[8] = '{32'h00000012, 32'h00000034, 64'h0000000000000408, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    a_bcd = '0;
    b_bcd = '0;
    repeat (2) @(negedge clk);
    check("reset_busy",    64'(busy),    64'd0);
    check("reset_done",    64'(done),    64'd0);
    check("reset_err",     64'(err),     64'd0);
    check("reset_product", product,      64'd0);
    check("reset_mul_xy",  64'({mul_x, mul_y}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven operations, issued back to back.
    for (int v = 0; v < 9; v++) begin
      run_op(vecs[v].a, vecs[v].b, 1'b0, p, e, dc, ok);
      check($sformatf("vec%0d_product", v), p, vecs[v].prod);
      check($sformatf("vec%0d_err", v), 64'(e), 64'(vecs[v].e));
      check($sformatf("vec%0d_done_cycle", v), 64'(dc), vecs[v].e ? 64'd2 : 64'd66);
      check($sformatf("vec%0d_invariants", v), 64'(ok), 64'd1);
    end

    // Start pulsed during RUN with new operands: ignored, single done.
    run_op(32'h00000012, 32'h00000034, 1'b1, p, e, dc, ok);
    check("inject_product",    p,       64'h408);
    check("inject_done_cycle", 64'(dc), 64'd66);
    check("inject_invariants", 64'(ok), 64'd1);
    extra_done = 0;
    repeat (70) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check("inject_no_second_done", 64'(extra_done), 64'd0);
    check("inject_idle", 64'(busy), 64'd0);

    // Asynchronous reset mid-RUN discards the operation.
    a_bcd = 32'h12345678;
    b_bcd = 32'h87654321;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy",    64'(busy),   64'd0);
    check("midrst_product", product,     64'd0);
    check("midrst_done",    64'(done),   64'd0);
    check("midrst_mul_x",   64'(mul_x),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(32'h00000001, 32'h00000007, 1'b0, p, e, dc, ok);
    check("postrst_product",    p,       64'd7);
    check("postrst_err",        64'(e),  64'd0);
    check("postrst_done_cycle", 64'(dc), 64'd66);
    check("postrst_invariants", 64'(ok), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
